// File: rtl/audio_delay_ctrl.sv
// Sequencing controller for the audio delay-line dual-port RAM: zero-fill after
// reset/flush, circular write on port A, delayed read on port B, delayed output strobe.
module audio_delay_ctrl #(
    parameter int unsigned DEPTH         = 3072,
    parameter int unsigned AW            = 12,
    parameter int unsigned DW            = 16,
    parameter int unsigned DEFAULT_DELAY = 480
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [AW-1:0] delay_len,
    input  logic          delay_load,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_in_valid,
    output logic          sample_in_ready,
    output logic [DW-1:0] sample_out,
    output logic          sample_out_valid,
    output logic          busy,
    output logic [AW-1:0] ada,
    output logic [DW-1:0] dina,
    output logic          cea,
    output logic          wrea,
    output logic          ocea,
    output logic [AW-1:0] adb,
    output logic [DW-1:0] dinb,
    output logic          ceb,
    output logic          wreb,
    output logic          oceb,
    input  logic [DW-1:0] doutb
);

    localparam logic [0:0]    ST_CLEAR  = 1'b0;
    localparam logic [0:0]    ST_RUN    = 1'b1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] DEPTH_AW  = AW'(DEPTH);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] delay_q, delay_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] ada_q, ada_d;
    logic [DW-1:0] dina_q, dina_d;
    logic          cea_q, cea_d;
    logic          wrea_q, wrea_d;
    logic [AW-1:0] adb_q, adb_d;
    logic          ceb_q, ceb_d;
    logic          s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic          s1_byp_q, s1_byp_d, s2_byp_q, s2_byp_d;
    logic [DW-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
    logic [DW-1:0] sample_out_q, sample_out_d;
    logic          sample_out_valid_q, sample_out_valid_d;

    logic          accept;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] delay_clamped;

    assign accept        = sample_in_valid && ready_q && (state_q == ST_RUN);
    // Modulo-DEPTH subtraction: borrow adds DEPTH rather than wrapping at 2**AW.
    assign rd_addr       = (wr_ptr_q >= delay_q) ? (wr_ptr_q - delay_q)
                                                 : (wr_ptr_q + DEPTH_AW - delay_q);
    assign delay_clamped = (delay_len > LAST_ADDR) ? LAST_ADDR : delay_len;

    always_comb begin
        state_d            = state_q;
        clr_addr_d         = clr_addr_q;
        wr_ptr_d           = wr_ptr_q;
        delay_d            = delay_q;
        ada_d              = ada_q;
        dina_d             = dina_q;
        cea_d              = 1'b0;
        wrea_d             = 1'b0;
        adb_d              = adb_q;
        ceb_d              = 1'b0;
        s1_vld_d           = 1'b0;
        s1_byp_d           = s1_byp_q;
        s1_data_d          = s1_data_q;
        s2_vld_d           = s1_vld_q;
        s2_byp_d           = s1_byp_q;
        s2_data_d          = s1_data_q;
        sample_out_d       = sample_out_q;
        sample_out_valid_d = s2_vld_q;

        if (s2_vld_q) begin
            sample_out_d = s2_byp_q ? s2_data_q : doutb;
        end
        if (delay_load) begin
            delay_d = delay_clamped;
        end

        if (flush) begin
            state_d            = ST_CLEAR;
            clr_addr_d         = '0;
            wr_ptr_d           = '0;
            s2_vld_d           = 1'b0;
            sample_out_d       = sample_out_q;
            sample_out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ada_d  = clr_addr_q;
                    dina_d = '0;
                    cea_d  = 1'b1;
                    wrea_d = 1'b1;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d    = ST_RUN;
                        clr_addr_d = '0;
                    end else begin
                        clr_addr_d = clr_addr_q + AW'(1);
                    end
                end
                default: begin
                    if (accept) begin
                        ada_d     = wr_ptr_q;
                        dina_d    = sample_in;
                        cea_d     = 1'b1;
                        wrea_d    = 1'b1;
                        adb_d     = rd_addr;
                        // Zero delay would read the address being written; bypass the RAM.
                        ceb_d     = (delay_q != '0);
                        wr_ptr_d  = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
                        s1_vld_d  = 1'b1;
                        s1_byp_d  = (delay_q == '0);
                        s1_data_d = sample_in;
                    end
                end
            endcase
        end

        ready_d = (state_q == ST_RUN) && !flush;
        busy_d  = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= ST_CLEAR;
            clr_addr_q         <= '0;
            wr_ptr_q           <= '0;
            delay_q            <= AW'(DEFAULT_DELAY);
            ready_q            <= 1'b0;
            busy_q             <= 1'b1;
            ada_q              <= '0;
            dina_q             <= '0;
            cea_q              <= 1'b0;
            wrea_q             <= 1'b0;
            adb_q              <= '0;
            ceb_q              <= 1'b0;
            s1_vld_q           <= 1'b0;
            s1_byp_q           <= 1'b0;
            s1_data_q          <= '0;
            s2_vld_q           <= 1'b0;
            s2_byp_q           <= 1'b0;
            s2_data_q          <= '0;
            sample_out_q       <= '0;
            sample_out_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            clr_addr_q         <= clr_addr_d;
            wr_ptr_q           <= wr_ptr_d;
            delay_q            <= delay_d;
            ready_q            <= ready_d;
            busy_q             <= busy_d;
            ada_q              <= ada_d;
            dina_q             <= dina_d;
            cea_q              <= cea_d;
            wrea_q             <= wrea_d;
            adb_q              <= adb_d;
            ceb_q              <= ceb_d;
            s1_vld_q           <= s1_vld_d;
            s1_byp_q           <= s1_byp_d;
            s1_data_q          <= s1_data_d;
            s2_vld_q           <= s2_vld_d;
            s2_byp_q           <= s2_byp_d;
            s2_data_q          <= s2_data_d;
            sample_out_q       <= sample_out_d;
            sample_out_valid_q <= sample_out_valid_d;
        end
    end

    assign sample_in_ready  = ready_q;
    assign sample_out       = sample_out_q;
    assign sample_out_valid = sample_out_valid_q;
    assign busy             = busy_q;
    assign ada              = ada_q;
    assign dina             = dina_q;
    assign cea              = cea_q;
    assign wrea             = wrea_q;
    assign ocea             = 1'b1;
    assign adb              = adb_q;
    assign dinb             = '0;
    assign ceb              = ceb_q;
    assign wreb             = 1'b0;
    assign oceb             = 1'b1;

endmodule

// File: tb/tb_audio_delay_ctrl.sv
// Randomized bench for audio_delay_ctrl: RAM model plus a sample-history reference
// model that predicts port activity, ready/busy timing and delayed outputs.
module tb_audio_delay_ctrl;

    localparam int unsigned DEPTH         = 3072;
    localparam int unsigned AW            = 12;
    localparam int unsigned DW            = 16;
    localparam int unsigned DEFAULT_DELAY = 480;

    logic          clk = 1'b0;
    logic          reset, flush, delay_load, sample_in_valid;
    logic [AW-1:0] delay_len;
    logic [DW-1:0] sample_in;
    logic          sample_in_ready, sample_out_valid, busy;
    logic [DW-1:0] sample_out, dina, dinb, doutb;
    logic [AW-1:0] ada, adb;
    logic          cea, wrea, ocea, ceb, wreb, oceb;

    always #5 clk = ~clk;

    audio_delay_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .DEFAULT_DELAY(DEFAULT_DELAY)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .delay_len(delay_len), .delay_load(delay_load),
        .sample_in(sample_in), .sample_in_valid(sample_in_valid),
        .sample_in_ready(sample_in_ready),
        .sample_out(sample_out), .sample_out_valid(sample_out_valid),
        .busy(busy),
        .ada(ada), .dina(dina), .cea(cea), .wrea(wrea), .ocea(ocea),
        .adb(adb), .dinb(dinb), .ceb(ceb), .wreb(wreb), .oceb(oceb),
        .doutb(doutb)
    );

    // Block RAM model; starts with garbage so a missing clear is visible.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] <= DW'($urandom);
        doutb <= DW'($urandom);
    end
    always @(posedge clk) begin
        if (cea && wrea && (int'(ada) < int'(DEPTH))) mem[ada] <= dina;
        if (ceb && (int'(adb) < int'(DEPTH))) doutb <= mem[adb];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    endtask

    // Reference model: edges since clear began, active delay, samples accepted since clear.
    typedef struct { int due; logic [DW-1:0] val; } exp_t;
    int unsigned   clr_cnt = 0;
    int unsigned   m_delay = DEFAULT_DELAY;
    logic [DW-1:0] hist[$];
    exp_t          expq[$];

    function automatic int unsigned clampd(input logic [AW-1:0] v);
        int unsigned x;
        x = v;
        if (x > DEPTH - 1) x = DEPTH - 1;
        return x;
    endfunction

    task automatic step();
        bit            acc;
        int unsigned   d_used, k, wp;
        logic [DW-1:0] ev;
        exp_t          e;
        @(posedge clk);
        #1;
        edge_n++;
        acc    = !reset && !flush && sample_in_valid && (clr_cnt >= DEPTH + 1);
        d_used = m_delay;
        k      = hist.size();
        if (reset) begin
            clr_cnt = 0;
            m_delay = DEFAULT_DELAY;
            hist.delete();
            expq.delete();
        end else begin
            if (flush) begin
                clr_cnt = 0;
                hist.delete();
                expq.delete();
            end else if (clr_cnt < DEPTH + 1) begin
                clr_cnt++;
            end
            if (delay_load) m_delay = clampd(delay_len);
        end
        if (acc) begin
            if (d_used == 0)     ev = sample_in;
            else if (k >= d_used) ev = hist[k - d_used];
            else                  ev = '0;
            e.due = edge_n + 2;
            e.val = ev;
            expq.push_back(e);
            hist.push_back(sample_in);
        end

        check("ready", 32'(sample_in_ready), 32'(clr_cnt >= DEPTH + 1));
        check("busy", 32'(busy), 32'(clr_cnt < DEPTH));
        if (reset) begin
            check("rst_sample_out", 32'(sample_out), 32'd0);
            check("rst_ada", 32'(ada), 32'd0);
            check("rst_adb", 32'(adb), 32'd0);
        end
        if (clr_cnt >= 1 && clr_cnt <= DEPTH) begin
            check("clr_cea", 32'(cea), 32'd1);
            check("clr_wrea", 32'(wrea), 32'd1);
            check("clr_ada", 32'(ada), clr_cnt - 1);
            check("clr_dina", 32'(dina), 32'd0);
            check("clr_ceb", 32'(ceb), 32'd0);
        end else if (acc) begin
            wp = k % DEPTH;
            check("wr_cea", 32'(cea), 32'd1);
            check("wr_wrea", 32'(wrea), 32'd1);
            check("wr_ada", 32'(ada), wp);
            check("wr_dina", 32'(dina), 32'(sample_in));
            check("rd_ceb", 32'(ceb), 32'(d_used != 0));
            if (d_used != 0) check("rd_adb", 32'(adb), (wp + DEPTH - d_used) % DEPTH);
        end else begin
            check("idle_cea", 32'(cea), 32'd0);
            check("idle_wrea", 32'(wrea), 32'd0);
            check("idle_ceb", 32'(ceb), 32'd0);
        end
        if (expq.size() > 0 && expq[0].due == edge_n) begin
            check("out_valid", 32'(sample_out_valid), 32'd1);
            check("out_data", 32'(sample_out), 32'(expq[0].val));
            void'(expq.pop_front());
        end else begin
            check("out_valid_idle", 32'(sample_out_valid), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        sample_in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic load(input int unsigned v);
        delay_len       = AW'(v);
        delay_load      = 1'b1;
        sample_in_valid = 1'b0;
        step();
        delay_load      = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] v);
        sample_in       = v;
        sample_in_valid = 1'b1;
        step();
        sample_in_valid = 1'b0;
    endtask

    task automatic run_clear();
        sample_in_valid = 1'b0;
        repeat (DEPTH + 1) step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; delay_load = 1'b0; delay_len = '0;
        sample_in = 16'h5A5A; sample_in_valid = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        // Valid held high through the whole clear: nothing may be accepted.
        repeat (DEPTH + 1) step();
        sample_in_valid = 1'b0;

        check("ocea_tie", 32'(ocea), 32'd1);
        check("oceb_tie", 32'(oceb), 32'd1);
        check("dinb_tie", 32'(dinb), 32'd0);
        check("wreb_tie", 32'(wreb), 32'd0);

        load(4);
        send(16'h7FFF);
        repeat (6) send(16'h0000);
        idle(4);

        load(0);
        send(16'h1234);
        idle(3);

        // Pointer wrap with value = index, starting from a fresh clear.
        flush = 1'b1; step(); flush = 1'b0;
        run_clear();
        load(3);
        for (int i = 0; i < int'(DEPTH) + 3; i++) send(DW'(i));
        idle(3);

        // Clamp of oversized delays.
        load(12'hFFF);
        repeat (4) send(DW'($urandom));
        idle(3);
        load(DEPTH);
        repeat (3) send(DW'($urandom));
        idle(3);

        // Random traffic with occasional delay changes, some coinciding with accepts.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                delay_load = 1'b1;
                case ($urandom_range(0, 3))
                    0:       delay_len = AW'(0);
                    1:       delay_len = AW'($urandom_range(1, 3));
                    2:       delay_len = AW'($urandom_range(3071, 4095));
                    default: delay_len = AW'($urandom_range(0, 40));
                endcase
            end
            sample_in       = DW'($urandom);
            sample_in_valid = ($urandom_range(0, 3) != 0);
            step();
            delay_load = 1'b0;
        end
        idle(3);

        // Flush with two samples in flight; delay must survive.
        load(7);
        repeat (5) send(DW'($urandom));
        sample_in = DW'($urandom); sample_in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; sample_in_valid = 1'b0;
        repeat (100) step();
        flush = 1'b1; step(); flush = 1'b0;
        run_clear();
        repeat (10) send(DW'($urandom));
        idle(3);

        // Reset mid-stream restores the default delay.
        load(9);
        repeat (4) send(DW'($urandom));
        reset = 1'b1; step(); step(); reset = 1'b0;
        run_clear();
        repeat (10) send(DW'($urandom));
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
